instr_decoder: RTL

//  Decode stage between fetch and the ALU. Accepts 32-bit RV32 instructions over a valid/ready handshake.

---
 rtl/core_pkg.sv | 36 +++
 rtl/skid_buffer.sv | 80 ++++++++
 rtl/instr_decoder.sv | 99 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared decode types and encodings for the RV32 decode stage.
package core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int IMM_W = 12;

    // imm holds the raw 12-bit I-immediate (or zero-extended shamt); widened at the output
    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [IMM_W-1:0] imm;
        logic             use_imm;
        logic             illegal;
    } dec_pkt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    function automatic logic alu_op_legal(input logic [2:0] func3, input logic [6:0] func7);
        return (func7 == F7_BASE) ||
               ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101)));
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry registered valid/ready slice with flush; full throughput, one cycle latency.
//  state | meaning
//  EMPTY | no word held, out_valid low
//  ONE   | word in main register, presented downstream
//  TWO   | main presented, skid holds the next word, input stalled
module skid_buffer
    import core_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  T     in_data,
    input  logic in_valid,
    output logic in_ready,
    output T     out_data,
    output logic out_valid,
    input  logic out_ready
);

    buf_state_e state;
    T           main_q;
    T           skid_q;
    logic       in_xfer;
    logic       out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign out_data = main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer) begin
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_decoder.sv
// RV32 decode stage: field split, legality check, skid-buffered output, illegal counter.
// Define DECODE_IMM_EN to accept OP-IMM and produce immediates; otherwise no immediate logic.
module instr_decoder
    import core_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int ILL_CNT_W     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [31:0]              instr_i,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    output logic [6:0]               opcode_o,
    output logic [2:0]               func3_o,
    output logic [6:0]               func7_o,
    output logic [4:0]               rd_addr_o,
    output logic [4:0]               rs1_addr_o,
    output logic [4:0]               rs2_addr_o,
    output logic [REGISTER_SIZE-1:0] imm_o,
    output logic                     use_imm_o,
    output logic                     illegal_o,
    output logic                     dec_valid_o,
    input  logic                     dec_ready_i,
    output logic [ILL_CNT_W-1:0]     ill_cnt_o
);

    dec_pkt_t dec_d;
    dec_pkt_t dec_q;

    always_comb begin
        dec_d         = '0;
        dec_d.opcode  = instr_i[6:0];
        dec_d.rd      = instr_i[11:7];
        dec_d.func3   = instr_i[14:12];
        dec_d.rs1     = instr_i[19:15];
        dec_d.rs2     = instr_i[24:20];
        dec_d.func7   = instr_i[31:25];
        dec_d.illegal = 1'b1;
        if (dec_d.opcode == OPC_OP) begin
            dec_d.illegal = !alu_op_legal(dec_d.func3, dec_d.func7);
        end
`ifdef DECODE_IMM_EN
        else if (dec_d.opcode == OPC_OP_IMM) begin
            dec_d.use_imm = 1'b1;
            case (dec_d.func3)
                3'b001: begin
                    dec_d.illegal = (dec_d.func7 != F7_BASE);
                    dec_d.imm     = {{(IMM_W-5){1'b0}}, instr_i[24:20]};
                end
                3'b101: begin
                    dec_d.illegal = !((dec_d.func7 == F7_BASE) || (dec_d.func7 == F7_ALT));
                    dec_d.imm     = {{(IMM_W-5){1'b0}}, instr_i[24:20]};
                end
                default: begin
                    dec_d.illegal = 1'b0;
                    dec_d.imm     = instr_i[31:20];
                end
            endcase
        end
`endif
    end

    skid_buffer #(
        .T(dec_pkt_t)
    ) u_skid (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (flush_i),
        .in_data   (dec_d),
        .in_valid  (instr_valid_i),
        .in_ready  (instr_ready_o),
        .out_data  (dec_q),
        .out_valid (dec_valid_o),
        .out_ready (dec_ready_i)
    );

    assign opcode_o   = dec_q.opcode;
    assign func3_o    = dec_q.func3;
    assign func7_o    = dec_q.func7;
    assign rd_addr_o  = dec_q.rd;
    assign rs1_addr_o = dec_q.rs1;
    assign rs2_addr_o = dec_q.rs2;
    assign use_imm_o  = dec_q.use_imm;
    assign illegal_o  = dec_q.illegal;
    // shift amounts are stored with bit 11 clear, so one sign extension serves both forms
    assign imm_o      = {{(REGISTER_SIZE-IMM_W){dec_q.imm[IMM_W-1]}}, dec_q.imm};

    // counts at the output handshake, so a transfer completing in a flush cycle still counts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ill_cnt_o <= '0;
        end else if (dec_valid_o && dec_ready_i && dec_q.illegal && (ill_cnt_o != '1)) begin
            ill_cnt_o <= ill_cnt_o + 1'b1;
        end
    end

endmodule
